// File: rtl/arb_pkg.sv
// Shared constants, state encoding and rotating-priority pick
// for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] RST_LAST_OWNER = 2'd3;

  // Nearest set bit after 'last', wrapping; 'last' itself is lowest.
  function automatic logic [N_REQ-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [IDX_W-1:0] last
  );
    logic [IDX_W-1:0] idx;
    rr_pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (req[idx]) begin
        rr_pick = '0;
        rr_pick[idx] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/arb_onehot_enc.sv
// One-hot to binary index encoder; zero input gives index 0.
module arb_onehot_enc
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot_i,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    idx_o = '0;
    unique case (1'b1)
      onehot_i[0]: idx_o = 2'd0;
      onehot_i[1]: idx_o = 2'd1;
      onehot_i[2]: idx_o = 2'd2;
      onehot_i[3]: idx_o = 2'd3;
      default:     idx_o = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Registered 4-way round-robin arbiter with hold-while-requesting.
// Optional hold timeout / preemption: define ARB_TIMEOUT_EN.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_id,
  output logic             grant_valid
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD out of range");
  end

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gid_q, gid_d;
  logic             gvld_q, gvld_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] others;
  logic             owner_req;
  logic             rearb;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  assign others    = req & ~grant_q;
  assign owner_req = |(req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    rearb   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = rr_pick(req, last_q);
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          rearb = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          rearb = |others;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
        if (rearb) begin
          last_d  = gid_q;
          grant_d = rr_pick(others, gid_q);
          state_d = (|others) ? GRANT : IDLE;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  arb_onehot_enc u_enc (
    .onehot_i (grant_d),
    .idx_o    (gid_d)
  );

  assign gvld_d = |grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      gvld_q  <= 1'b0;
      last_q  <= RST_LAST_OWNER;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      gvld_q  <= gvld_d;
      last_q  <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign grant       = grant_q;
  assign grant_id    = gid_q;
  assign grant_valid = gvld_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with an integer-level
// owner/priority model compared every cycle.
module tb_rr_arbiter_4;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b1111;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_last  = 3;
  int m_held  = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  function automatic int pick(
    input logic [3:0] r,
    input int from,
    input int excl
  );
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4] && ((from + k) % 4) != excl)
        return (from + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 3;
      m_held  <= 0;
    end else if (m_owner < 0) begin
      m_owner <= pick(req, m_last, -1);
      m_held  <= 0;
    end else if (!req[m_owner]) begin
      m_last  <= m_owner;
      m_owner <= pick(req, m_owner, m_owner);
      m_held  <= 0;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_held == MH - 1 &&
             pick(req, m_owner, m_owner) >= 0) begin
      m_last  <= m_owner;
      m_owner <= pick(req, m_owner, m_owner);
      m_held  <= 0;
    end else if (m_held < MH - 1) begin
      m_held <= m_held + 1;
    end
`endif
  end

  always @(negedge clk) begin
    logic [3:0] eg;
    logic [1:0] ei;
    eg = 4'b0000;
    ei = 2'd0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ei = 2'(m_owner);
    end
    checks++;
    if (grant !== eg || grant_id !== ei ||
        grant_valid !== (m_owner >= 0)) begin
      errors++;
      $display("FAIL model t=%0t grant=%b id=%0d v=%b exp %b %0d %b",
               $time, grant, grant_id, grant_valid,
               eg, ei, (m_owner >= 0));
    end
  end

  task automatic chk(
    input string name,
    input logic [3:0] act,
    input logic [3:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(negedge clk);
  endtask

  logic [3:0] tbl [16] = '{
    4'b0011, 4'b0011, 4'b0010, 4'b0000,
    4'b1100, 4'b1100, 4'b0100, 4'b0110,
    4'b0001, 4'b0000, 4'b1111, 4'b0111,
    4'b0011, 4'b0001, 4'b0000, 4'b1001
  };

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_id", {2'b00, grant_id}, 4'b0000);
    chk("rst_valid", {3'b000, grant_valid}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", grant, 4'b0001);
    chk("post_rst_valid", {3'b000, grant_valid}, 4'b0001);

    step(4'b1110);
    chk("rot1", grant, 4'b0010);
    step(4'b1101);
    chk("rot2", grant, 4'b0100);
    chk("rot2_id", {2'b00, grant_id}, 4'd2);
    step(4'b1011);
    chk("rot3", grant, 4'b1000);
    step(4'b0111);
    chk("rot4", grant, 4'b0001);
    chk("rot4_valid", {3'b000, grant_valid}, 4'b0001);

`ifndef ARB_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      step(4'b0101);
      chk("hold", grant, 4'b0001);
    end
`else
    step(4'b0101);
`endif
    step(4'b0100);
    chk("hold_release", grant, 4'b0100);

    step(4'b0000);
    chk("empty_grant", grant, 4'b0000);
    chk("empty_valid", {3'b000, grant_valid}, 4'b0000);

    step(4'b1000);
    chk("pre_areset", grant, 4'b1000);
    #2 rst_n = 1'b0;
    #1 chk("areset_async", grant, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000);
    chk("areset_regrant", grant, 4'b1000);

    step(4'b0110);
    chk("rot_pick", grant, 4'b0010);
    step(4'b0100);
    chk("rot_pick2", grant, 4'b0100);

    foreach (tbl[i]) step(tbl[i]);

`ifdef ARB_TIMEOUT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < MH; c++) begin
        chk("timeout", grant,
            (r % 2 == 0) ? 4'b0010 : 4'b1000);
        @(negedge clk);
      end
    end
`endif

    req = 4'b0000;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Registered round-robin arbiter that shares one downstream resource between 4 requesters.
- Produces a one-hot grant plus a 2-bit encoded grant index for muxing the shared datapath.
- The owner holds the grant for as long as it keeps its request asserted.
- Sits between the requesting agents and the resource-select mux.

Parameters:
- MAX_HOLD, 8: maximum cycles one owner may hold the grant while others wait. Range 2..255. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request vector; bit i is requester i. Level-sensitive.
- grant  out  4  one-hot grant, registered; all-zero when no owner.
- grant_id  out  2  binary index of the set grant bit; 0 when grant is 0.
- grant_valid  out  1  high when grant is non-zero.

Behaviour:
- Clocking/reset: one clock (clk); rst_n is asynchronous and active-low.
- Reset values: grant=4'b0000, grant_id=2'b00, grant_valid=0, state=IDLE, last_owner=3 (so requester 0 has top priority first), hold_cnt=0.
- States: IDLE (no owner) and GRANT (owner registered).
- Priority search: rotating, starting at (last_owner+1) mod 4 and wrapping 3->0. Simultaneous requests resolve strictly by this rotation.
- IDLE, req==0: stay in IDLE; outputs stay at their reset values.
- IDLE, req!=0: at the next edge, grant the winner and go to GRANT. Latency from req rising to grant is 1 cycle.
- GRANT, req[owner]==1: hold the grant unchanged. Requests from other agents have no effect.
- GRANT, req[owner]==0: at the same edge, last_owner<=owner and re-arbitrate among the remaining requests.
  - If any remain, grant the new winner directly (back-to-back handoff, no idle cycle).
  - If none remain, grant<=0 and go to IDLE.
- Transitions: GRANT->GRANT on handoff; GRANT->IDLE on release with no pending requests; no direct IDLE->IDLE grant.
- Re-requests: a requester that drops req and re-raises it in the next cycle is treated as a new request at its rotated priority.
- No speculative output: grant never changes combinationally from req. grant_id and grant_valid are registered alongside grant and are always consistent with it.
- Undefined inputs: req bits that are X/Z are not supported. The bench drives only 0/1.
- Reset mid-operation: asserting rst_n low drops grant to 0 immediately (asynchronously) and restores last_owner=3.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold_cnt increments each cycle in GRANT and clears on every new grant.
  - When hold_cnt==MAX_HOLD-1 and any other req bit is set, the arbiter forcibly re-arbitrates at the next edge, excluding the current owner; the preempted owner becomes last_owner.
  - If no other requester is waiting, hold_cnt saturates and the owner keeps the grant.
- Undefined: no counter and no preemption; the owner holds the grant indefinitely.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=4 and the IDX_W=2 constant.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Constant RST_LAST_OWNER=2'd3.
- Sub-module arb_onehot_enc: combinational 4-bit one-hot to 2-bit index. It is used to derive the next grant_id from the next-grant vector before the register stage.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111, then release -> grant=0001, grant_id=0, grant_valid=1 one edge after release.
- Rotation: req=4'b1111 held, each owner drops its req for one cycle in turn -> grant sequence 0001,0010,0100,1000,0001 with back-to-back handoffs and no grant_valid gap.
- Hold: req=4'b0101 with req[0] held for 20 cycles (macro undefined) -> grant stays 0001 for all 20 cycles. Drop req[0] -> grant=0100 at the next edge.
- Empty release: only req[2] set, then dropped -> grant=0100, then 0000 with grant_valid=0 one edge after the drop. State returns to IDLE.
- Async reset mid-grant: assert rst_n low mid-cycle while grant=1000 -> grant=0000 before the next clk edge. After release with req=4'b1000, grant=1000 after 1 cycle.
- ARB_TIMEOUT_EN, MAX_HOLD=8: req[1] and req[3] held high -> grant=0010 for exactly 8 cycles, then 1000 for 8 cycles, alternating.
